spi_slave: RTL
==============

# spi_slave

Byte-oriented SPI slave, the peripheral-side counterpart of `SPI_Master`. It oversamples the external SPI pins (SCLK, MOSI, SS_n) on the system clock and supports all four CPOL/CPHA modes, MSB first. Each received byte is presented on a parallel port with a one-cycle `done` strobe, and the transmit byte is shifted out on MISO during the same frame. It sits between the SPI pins and an AXI-Lite register wrapper.

## Interface
Parameters:
- `DATA_W`, 8, bits per SPI byte.
- `SYNC_STAGES`, 2, synchronizer depth on SCLK/MOSI/SS_n; minimum 2.

Ports:
- `clk`  in  1  system clock. All state is updated on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0, released synchronously to `clk`).
- `CPOL`  in  1  SCLK idle level; sampled at SS_n assertion.
- `CPHA`  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at SS_n assertion.
- `SCLK`  in  1  SPI clock from the master (asynchronous).
- `MOSI`  in  1  serial data from the master (asynchronous).
- `SS_n`  in  1  active-low slave select (asynchronous).
- `MISO`  out  1  serial data to the master.
- `MISO_oe`  out  1  MISO output enable; high only while selected.
- `tx_data`  in  DATA_W  byte to transmit; captured at each byte start.
- `tx_req`  out  1  one-cycle pulse when `tx_data` has been captured; upstream may change `tx_data` after it.
- `rx_data`  out  DATA_W  last complete received byte; holds until the next byte completes.
- `done`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  high while a frame is in progress (state ACTIVE).

## Operation
- SCLK, MOSI and SS_n each pass through a `SYNC_STAGES` flop chain. Edges of SCLK and SS_n are detected by comparing the last synchronizer stage with one additional registered copy.
- Leading edge: the SCLK transition away from CPOL. Trailing edge: the transition back to CPOL.
- States:
  - IDLE: SS_n high. `MISO_oe`=0 and `MISO`=0.
  - ACTIVE: SS_n low.
- IDLE -> ACTIVE on a synchronized SS_n falling edge. In the same cycle:
  - latch CPOL and CPHA into `mode_q`;
  - load `tx_data` into the TX shift register;
  - pulse `tx_req`;
  - clear the 3-bit bit counter.
- ACTIVE -> IDLE on a synchronized SS_n rising edge from any bit position. A partial byte is discarded: no `done`, `rx_data` unchanged.
- CPHA=0:
  - MISO presents TX bit 7 immediately on entering ACTIVE.
  - Leading edge: sample MOSI into the RX shift register (shift left, LSB in).
  - Trailing edge: shift TX left and present the next bit.
- CPHA=1:
  - Leading edge: present the next TX bit; the first leading edge presents bit 7.
  - Trailing edge: sample MOSI.
- The bit counter increments on every sample edge. On the 8th sample:
  - `rx_data` <= the full byte;
  - pulse `done`;
  - wrap the counter to 0;
  - reload the TX shift register from `tx_data` and pulse `tx_req`, so back-to-back bytes are supported within one SS_n frame. For CPHA=0 the reload takes effect at the following trailing edge, which presents the new bit 7.
- CPOL/CPHA changes while ACTIVE are ignored until the next frame.
- `MISO` is registered. `MISO_oe` = (state == ACTIVE).

## Timing
- Reset values: `MISO`=0, `MISO_oe`=0, `tx_req`=0, `rx_data`=0, `done`=0, `busy`=0, state IDLE, all synchronizers at their idle levels (SCLK 0, SS_n 1).
- Input-to-action latency is `SYNC_STAGES`+1 clk cycles from a pin change.
- SCLK high and low times must each be at least `SYNC_STAGES`+3 clk cycles. SS_n setup before the first SCLK edge must be at least `SYNC_STAGES`+2 cycles.
- `done` asserts in the cycle after the 8th sample edge is detected, for exactly one cycle. `rx_data` is valid in the same cycle and stays valid afterwards.
- An SCLK edge and an SS_n rising edge detected in the same cycle: SS_n wins, the edge is ignored, and the frame aborts.
- An SCLK edge arriving in IDLE has no effect.
- Reset asserted mid-frame forces all reset values immediately (asynchronously).

## Structure
- Shared package `spi_pkg`:
  - `typedef enum logic {IDLE, ACTIVE} spi_slv_state_e`;
  - `typedef struct packed {logic cpol; logic cpha;} spi_mode_t`;
  - constant `SPI_DATA_W = 8`.
- Sub-module `spi_sync_edge` (one instance per SCLK and SS_n, plus a sync-only use for MOSI): `SYNC_STAGES` flops plus edge outputs `rise` and `fall`.

## Test plan
- Mode 3 (CPOL=1, CPHA=1): `SPI_Master` sends 8'hAA with the slave's `tx_data`=8'h55. Required: slave `rx_data`=8'hAA with one `done` pulse; master `rx_data`=8'h55.
- All four modes, master byte 8'hC3, slave byte 8'h3C: both sides receive the other's byte correctly in every mode.
- Back-to-back bytes in one SS_n frame (8'h01, 8'h02), with `tx_data` updated after each `tx_req`. Required: two `done` pulses, `rx_data` sequence 01 then 02, MISO carries both slave bytes.
- SS_n deasserted after 5 SCLK edges: no `done`, `rx_data` holds its previous value, `MISO_oe`=0 within `SYNC_STAGES`+2 cycles; the next full frame with 8'hF0 receives correctly.
- `rst` driven low mid-byte: all outputs return to reset values in the same cycle; after release, a frame with 8'h5A receives correctly.
- SCLK toggled with SS_n high: no `done`, no `tx_req`, `MISO_oe` stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave block.
//   spi_slv_state_e : slave frame state (IDLE / ACTIVE)
//   spi_mode_t      : CPOL/CPHA pair latched at the start of each frame
//   SPI_DATA_W      : default bits per SPI byte
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous pin.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   din   : asynchronous input pin
//   q     : synchronized level (last synchronizer stage)
//   rise  : combinational, high for one cycle after q goes 0->1
//   fall  : combinational, high for one cycle after q goes 1->0
// STAGES is the synchronizer depth (2 or more). RESET_VAL is the pin's idle
// level, so that leaving reset does not manufacture an edge on an idle pin.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= {STAGES{RESET_VAL}};
            prev_reg <= RESET_VAL;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign q    = sync_reg[STAGES-1];
    // Edges compare the last stage against one extra registered copy.
    assign rise =  sync_reg[STAGES-1] & ~prev_reg;
    assign fall = ~sync_reg[STAGES-1] &  prev_reg;

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI slave, all four CPOL/CPHA modes, MSB first.
// Pins are oversampled on clk; each received byte appears on rx_data with a
// one-cycle done strobe while tx_data is shifted out on MISO in the same frame.
//   clk, rst          : system clock, asynchronous active-low reset
//   CPOL, CPHA        : SPI mode, latched when SS_n asserts
//   SCLK, MOSI, SS_n  : asynchronous SPI pins from the master
//   MISO, MISO_oe     : serial data to the master and its output enable
//   tx_data, tx_req   : byte to send; tx_req pulses once it has been captured
//   rx_data, done     : last complete byte; done pulses when it updates
//   busy              : high while a frame is in progress
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              SS_n,
    output logic              MISO,
    output logic              MISO_oe,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    output logic [DATA_W-1:0] rx_data,
    output logic              done,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (SCLK),
        .q    (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk  (clk),
        .rst  (rst),
        .din  (SS_n),
        .q    (ss_s),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    // MOSI only needs its level; its edge outputs are not used.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rst  (rst),
        .din  (MOSI),
        .q    (mosi_s),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    logic pin_levels_unused;
    assign pin_levels_unused = &{1'b0, sclk_s, ss_s, mosi_rise, mosi_fall};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    spi_slv_state_e    state_reg,    state_next;
    spi_mode_t         mode_reg,     mode_next;
    logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
    logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
    logic [CNT_W-1:0]  bit_cnt_reg,  bit_cnt_next;
    logic              miso_reg,     miso_next;
    logic [DATA_W-1:0] rx_data_reg,  rx_data_next;
    logic              done_reg,     done_next;
    logic              tx_req_reg,   tx_req_next;

    // Leading edge leaves the idle level, trailing edge returns to it.
    logic lead_edge, trail_edge, sample_edge, shift_edge;

    assign lead_edge   = mode_reg.cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = mode_reg.cpol ? sclk_rise : sclk_fall;
    assign sample_edge = mode_reg.cpha ? trail_edge : lead_edge;
    assign shift_edge  = mode_reg.cpha ? lead_edge  : trail_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            mode_reg     <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            bit_cnt_reg  <= '0;
            miso_reg     <= 1'b0;
            rx_data_reg  <= '0;
            done_reg     <= 1'b0;
            tx_req_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            miso_reg     <= miso_next;
            rx_data_reg  <= rx_data_next;
            done_reg     <= done_next;
            tx_req_reg   <= tx_req_next;
        end
    end

    // tx_shift_reg[MSB] is always the next bit to put on MISO at a shift
    // edge. For CPHA=0 the first bit goes out on frame entry, so the shift
    // register is loaded pre-shifted; after a mid-frame reload the next
    // trailing edge therefore presents the new byte's MSB.
    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        miso_next     = miso_reg;
        rx_data_next  = rx_data_reg;
        done_next     = 1'b0;
        tx_req_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                miso_next = 1'b0;
                if (ss_fall) begin
                    state_next     = ACTIVE;
                    mode_next.cpol = CPOL;
                    mode_next.cpha = CPHA;
                    tx_req_next    = 1'b1;
                    bit_cnt_next   = '0;
                    rx_shift_next  = '0;
                    if (!CPHA) begin
                        miso_next     = tx_data[DATA_W-1];
                        tx_shift_next = tx_data << 1;
                    end else begin
                        tx_shift_next = tx_data;
                    end
                end
            end

            ACTIVE: begin
                if (ss_rise) begin
                    // Abort wins over any simultaneous SCLK edge; a partial
                    // byte is simply dropped.
                    state_next = IDLE;
                    miso_next  = 1'b0;
                end else if (sample_edge) begin
                    rx_shift_next = {rx_shift_reg[DATA_W-2:0], mosi_s};
                    if (bit_cnt_reg == LAST_BIT) begin
                        rx_data_next  = {rx_shift_reg[DATA_W-2:0], mosi_s};
                        done_next     = 1'b1;
                        bit_cnt_next  = '0;
                        tx_shift_next = tx_data;
                        tx_req_next   = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else if (shift_edge) begin
                    miso_next     = tx_shift_reg[DATA_W-1];
                    tx_shift_next = tx_shift_reg << 1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign MISO    = miso_reg;
    assign MISO_oe = (state_reg == ACTIVE);
    assign busy    = (state_reg == ACTIVE);
    assign rx_data = rx_data_reg;
    assign done    = done_reg;
    assign tx_req  = tx_req_reg;

endmodule
